// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback commit queue.
// WB_FORWARD_EN (optional) enables the query data path in the queue.
package wb_pkg;
  localparam int WB_DEPTH  = 4;
  localparam int WB_DATA_W = 32;
  localparam int WB_IDX_W  = 5;
  localparam int WB_PTR_W  = $clog2(WB_DEPTH);
  localparam int WB_CNT_W  = $clog2(WB_DEPTH + 1);

  typedef logic [WB_PTR_W-1:0] wb_ptr_t;
  typedef logic [WB_CNT_W-1:0] wb_cnt_t;

  typedef struct packed {
    logic [WB_IDX_W-1:0]  idx;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_match_unit.sv
// Newest-first search of queued entries for a pending write to query_idx.
// WB_FORWARD_EN adds the matched-data output; otherwise only hit is built.
module wb_match_unit
  import wb_pkg::*;
(
  input  logic [WB_IDX_W-1:0]  query_idx,
  input  wb_ptr_t              rd_ptr,
  input  logic [WB_DEPTH-1:0]  valid,
  input  logic [WB_IDX_W-1:0]  entry_idx [WB_DEPTH],
`ifdef WB_FORWARD_EN
  input  logic [WB_DATA_W-1:0] entry_data [WB_DEPTH],
  output logic [WB_DATA_W-1:0] match_data,
`endif
  output logic                 hit
);

  // Walk oldest to newest from rd_ptr so later matches overwrite earlier ones.
  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    wb_ptr_t slot;
    hit  = 1'b0;
    slot = rd_ptr;
`ifdef WB_FORWARD_EN
    match_data = '0;
`endif
    for (int k = 0; k < WB_DEPTH; k++) begin
      slot = rd_ptr + wb_ptr_t'(k);
      if (valid[slot] && (query_idx != '0) && (entry_idx[slot] == query_idx)) begin
        hit = 1'b1;
`ifdef WB_FORWARD_EN
        match_data = entry_data[slot];
`endif
      end
    end
  end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order writeback FIFO draining onto the regfile write port, with hazard query.
// WB_FORWARD_EN defined: queryData_out forwards newest matching data; else tied 0.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int DATA_W = WB_DATA_W,
  parameter int IDX_W  = WB_IDX_W
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IDX_W-1:0]           in_idx,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       stall_in,
  output logic                       writeE_out,
  output logic [IDX_W-1:0]           writeIdx_out,
  output logic [DATA_W-1:0]          writeData_out,
  input  logic [IDX_W-1:0]           queryIdx_in,
  output logic                       queryHit_out,
  output logic [DATA_W-1:0]          queryData_out,
  output logic [$clog2(DEPTH+1)-1:0] count_out
);

  wb_entry_t           mem [WB_DEPTH];
  wb_ptr_t             rd_ptr, wr_ptr;
  wb_cnt_t             count;
  logic                push, pop;
  logic [WB_DEPTH-1:0] valid;
  logic [WB_IDX_W-1:0] entry_idx [WB_DEPTH];
`ifdef WB_FORWARD_EN
  logic [WB_DATA_W-1:0] entry_data [WB_DEPTH];
`endif

  assign in_ready  = (count < wb_cnt_t'(WB_DEPTH));
  // Index-0 writes complete the handshake but are never stored.
  assign push      = in_valid && in_ready && (in_idx != '0);
  assign pop       = !stall_in && (count != '0);
  assign count_out = count;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      writeE_out    <= 1'b0;
      writeIdx_out  <= '0;
      writeData_out <= '0;
    end else begin
      writeE_out <= pop;
      if (pop) begin
        writeIdx_out  <= mem[rd_ptr].idx;
        writeData_out <= mem[rd_ptr].data;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + wb_cnt_t'(push) - wb_cnt_t'(pop);
    end
  end

  // NOTE: storage is not reset; occupancy is tracked by count, so stale slots are never visible.
  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= '{idx: in_idx, data: in_data};
  end

  // A slot is live when its age relative to rd_ptr is below the occupancy.
  always_comb begin
    wb_ptr_t age;
    age = '0;
    for (int s = 0; s < WB_DEPTH; s++) begin
      age          = wb_ptr_t'(s) - rd_ptr;
      valid[s]     = ({1'b0, age} < count);
      entry_idx[s] = mem[s].idx;
`ifdef WB_FORWARD_EN
      entry_data[s] = mem[s].data;
`endif
    end
  end

  wb_match_unit u_match (
    .query_idx  (queryIdx_in),
    .rd_ptr     (rd_ptr),
    .valid      (valid),
    .entry_idx  (entry_idx),
`ifdef WB_FORWARD_EN
    .entry_data (entry_data),
    .match_data (queryData_out),
`endif
    .hit        (queryHit_out)
  );

`ifndef WB_FORWARD_EN
  assign queryData_out = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Directed bench for wb_commit_queue with a scoreboard of expected regfile writes.
module tb_wb_commit_queue;
  import wb_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [WB_IDX_W-1:0]  in_idx;
  logic [WB_DATA_W-1:0] in_data;
  logic                 stall_in;
  logic                 writeE_out;
  logic [WB_IDX_W-1:0]  writeIdx_out;
  logic [WB_DATA_W-1:0] writeData_out;
  logic [WB_IDX_W-1:0]  queryIdx_in;
  logic                 queryHit_out;
  logic [WB_DATA_W-1:0] queryData_out;
  logic [WB_CNT_W-1:0]  count_out;

  int checks = 0;
  int errors = 0;
  wb_entry_t sb [$];

  always #5 clk_in = ~clk_in;

  wb_commit_queue dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_idx        (in_idx),
    .in_data       (in_data),
    .stall_in      (stall_in),
    .writeE_out    (writeE_out),
    .writeIdx_out  (writeIdx_out),
    .writeData_out (writeData_out),
    .queryIdx_in   (queryIdx_in),
    .queryHit_out  (queryHit_out),
    .queryData_out (queryData_out),
    .count_out     (count_out)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  // Offer one entry this cycle; record it as expected only when the DUT can take it.
  task automatic offer(input logic [WB_IDX_W-1:0] idx, input logic [WB_DATA_W-1:0] data);
    in_valid = 1'b1;
    in_idx   = idx;
    in_data  = data;
    if (in_ready && idx != '0) sb.push_back('{idx: idx, data: data});
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc();
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Every regfile write must match the oldest outstanding expectation.
  always @(negedge clk_in) begin
    if (!rst_in && writeE_out) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'(writeE_out), 64'd0);
      end else begin
        wb_entry_t e;
        e = sb.pop_front();
        check("write_idx", 64'(writeIdx_out), 64'(e.idx));
        check("write_data", 64'(writeData_out), 64'(e.data));
      end
    end
  end

  initial begin
    rst_in = 1'b1; in_valid = 1'b0; in_idx = '0; in_data = '0;
    stall_in = 1'b0; queryIdx_in = '0;
    cyc(); cyc();
    check("rst_count", 64'(count_out), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_we", 64'(writeE_out), 64'd0);
    check("rst_widx", 64'(writeIdx_out), 64'd0);
    check("rst_wdata", 64'(writeData_out), 64'd0);
    check("rst_hit", 64'(queryHit_out), 64'd0);
    check("rst_qdata", 64'(queryData_out), 64'd0);
    rst_in = 1'b0;

    // 1: latency of two cycles, single-cycle write pulse
    offer(5'd3, 32'hDEADBEEF);
    check("t1_we_n1", 64'(writeE_out), 64'd0);
    cyc();
    check("t1_we_n2", 64'(writeE_out), 64'd1);
    check("t1_idx_n2", 64'(writeIdx_out), 64'd3);
    check("t1_data_n2", 64'(writeData_out), 64'hDEADBEEF);
    cyc();
    check("t1_we_n3", 64'(writeE_out), 64'd0);
    check("t1_sb_empty", 64'(sb.size()), 64'd0);

    // 2: fill under stall, refuse fifth, then four back-to-back writes
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) offer(5'(i + 1), 32'h100 + 32'(i));
    check("t2_count_full", 64'(count_out), 64'd4);
    check("t2_ready_full", 64'(in_ready), 64'd0);
    offer(5'd9, 32'h999);
    check("t2_count_refused", 64'(count_out), 64'd4);
    stall_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t2_we_burst", 64'(writeE_out), 64'd1);
    end
    cyc();
    check("t2_we_after", 64'(writeE_out), 64'd0);
    check("t2_drained", 64'(sb.size()), 64'd0);

    // 3: newest-match forwarding and query idx 0 never hits
    stall_in = 1'b1;
    offer(5'd5, 32'h11);
    offer(5'd5, 32'h22);
    queryIdx_in = 5'd5; #1;
    check("t3_hit", 64'(queryHit_out), 64'd1);
`ifdef WB_FORWARD_EN
    check("t3_qdata", 64'(queryData_out), 64'h22);
`else
    check("t3_qdata", 64'(queryData_out), 64'h0);
`endif
    queryIdx_in = 5'd7; #1;
    check("t3_miss", 64'(queryHit_out), 64'd0);
    check("t3_miss_data", 64'(queryData_out), 64'h0);
    queryIdx_in = 5'd0; #1;
    check("t3_idx0", 64'(queryHit_out), 64'd0);
    queryIdx_in = 5'd5;
    stall_in = 1'b0;
    drain("t3_drained");
    cyc();
    check("t3_hit_after", 64'(queryHit_out), 64'd0);

    // 4: idx 0 completes handshake but is not stored
    check("t4_ready", 64'(in_ready), 64'd1);
    offer(5'd0, 32'hFFFF);
    check("t4_count", 64'(count_out), 64'd0);
    cyc();
    check("t4_we", 64'(writeE_out), 64'd0);
    queryIdx_in = 5'd0; #1;
    check("t4_hit0", 64'(queryHit_out), 64'd0);

    // 5: full + pop refuses push, then steady push/pop across wrap
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) offer(5'(10 + i), 32'hA000 + 32'(i));
    stall_in = 1'b0;
    offer(5'd20, 32'hBAD);
    check("t5_count_pop_full", 64'(count_out), 64'd3);
    for (int i = 0; i < 10; i++) begin
      offer(5'(1 + (i % 31)), 32'hC000 + 32'(i));
      check("t5_count_steady", 64'(count_out), 64'd3);
    end
    drain("t5_drained");
    cyc();
    check("t5_count_end", 64'(count_out), 64'd0);

    // 6: reset with entries queued discards them
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) offer(5'(25 + i), 32'hE000 + 32'(i));
    check("t6_count_pre", 64'(count_out), 64'd3);
    queryIdx_in = 5'd25;
    rst_in = 1'b1;
    cyc();
    sb.delete();
    check("t6_count", 64'(count_out), 64'd0);
    check("t6_we", 64'(writeE_out), 64'd0);
    check("t6_hit", 64'(queryHit_out), 64'd0);
    rst_in = 1'b0;
    stall_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t6_no_stale", 64'(writeE_out), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
